// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam int CNT_W  = $clog2(DW_DEF);

    // Wide all-ones patterns; users slice them to their own widths.
    localparam logic [63:0] DIV0_QUOT = '1;
    localparam logic [63:0] DIV0_REM  = '1;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module seq_div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] r,
    input  logic          dividend_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] r_next,
    output logic          q_bit
);

    logic [VW:0] r_shift;

    // The extra top bit keeps the compare exact when r' reaches 2*divisor-1.
    always_comb begin
        r_shift = {r, dividend_bit};
        q_bit   = (r_shift >= {1'b0, divisor});
        r_next  = q_bit ? VW'(r_shift - {1'b0, divisor}) : r_shift[VW-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per cycle.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = cnt_width(DW);

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;

    logic [VW-1:0] step_r;
    logic          step_bit;

    seq_div_step #(.VW(VW)) u_step (
        .r            (r_q),
        .dividend_bit (q_q[DW-1]),
        .divisor      (dvs_q),
        .r_next       (step_r),
        .q_bit        (step_bit)
    );

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the producer holds its data until the transfer.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        r_d       = r_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        dz_d      = dz_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        r_d     = '0;
                        dvs_d   = divisor;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end else begin
                        q_d     = DIV0_QUOT[DW-1:0];
                        r_d     = DIV0_REM[VW-1:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            // The dividend shifts out of q_q's MSB while quotient bits enter its LSB.
            CALC: begin
                q_d = {q_q[DW-2:0], step_bit};
                r_d = step_r;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div with hand-computed quotients and remainders.
module tb_seq_div;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW+VW:0] exp_q[$];

    seq_div #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, transfers one operand pair, then counts cycles until out_valid.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, input int exp_lat,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check_val("in_ready_before_send", in_ready, 1);
        exp_q.push_back({ez, eq, er});
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_val("latency", lat, exp_lat);
    endtask

    // Compares the held result against the scoreboard, then performs one output transfer.
    task automatic collect(input string tag);
        logic [DW+VW:0] e;
        check_val({tag, "_out_valid"}, out_valid, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_quotient"}, quotient, e[DW+VW-1:VW]);
            check_val({tag, "_remainder"}, remainder, e[VW-1:0]);
            check_val({tag, "_div_zero"}, div_zero, e[DW+VW]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_valid_dropped"}, out_valid, 0);
        check_val({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_quotient", quotient, 0);
        check_val("rst_remainder", remainder, 0);
        check_val("rst_div_zero", div_zero, 0);
        rst = 1'b0;
        tick();

        send(16'd30000, 8'd150, 17, 16'd200, 8'd0, 1'b0);
        collect("d30000_150");

        send(16'hFFFF, 8'hFF, 17, 16'h0101, 8'd0, 1'b0);
        collect("dffff_ff");
        send(16'd1000, 8'd7, 17, 16'd142, 8'd6, 1'b0);
        collect("d1000_7");

        send(16'd5, 8'd9, 17, 16'd0, 8'd5, 1'b0);
        collect("d5_9");
        send(16'd0, 8'd3, 17, 16'd0, 8'd0, 1'b0);
        collect("d0_3");

        send(16'd1234, 8'd0, 1, 16'hFFFF, 8'hFF, 1'b1);
        collect("d1234_0");
        send(16'd10, 8'd3, 17, 16'd3, 8'd1, 1'b0);
        collect("d10_3");

        // Backpressure with stray in_valid pulses that must be ignored.
        send(16'd500, 8'd7, 17, 16'd71, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            dividend = 16'd9;
            divisor  = 8'd1;
            in_valid = (i % 2 == 0);
            tick();
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_quotient", quotient, 16'd71);
            check_val("bp_remainder", remainder, 8'd3);
        end
        in_valid = 1'b0;
        collect("d500_7");
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_val("bp_single_transfer", seen, 0);

        // Abort an operation with reset once the counter has reached 8.
        dividend = 16'd40000;
        divisor  = 8'd200;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_quotient", quotient, 0);
        check_val("abort_remainder", remainder, 0);
        check_val("abort_div_zero", div_zero, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_val("abort_no_result", seen, 0);
        send(16'd100, 8'd10, 17, 16'd10, 8'd0, 1'b0);
        collect("d100_10");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
